// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of four source FIFOs into one destination FIFO
// The grant is combinational so a pop can be withdrawn in the same cycle almost_full or init rises.
module fifo_rr_arbiter #(
  parameter int DATA_W = 12,
  parameter int N_SRC  = 4,
  parameter int UMB_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMB_W-1:0]        full_umbral_in,
  input  logic [UMB_W-1:0]        empty_umbral_in,
  output logic [UMB_W-1:0]        full_umbral,
  output logic [UMB_W-1:0]        empty_umbral,
  input  logic [N_SRC-1:0]        src_empty,
  output logic [N_SRC-1:0]        src_rd,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    dest_almost_full,
  output logic [DATA_W-1:0]       dest_fifo_in,
  output logic                    dest_fifo_wr,
  output logic [1:0]              state,
  output logic                    idle
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t     st;
  logic [1:0] ptr;
  logic [1:0] rd_idx;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       any_ready;
  logic       grant;

  assign any_ready = |(~src_empty);
  assign grant     = (st == ST_ACTIVE) && !init && !dest_almost_full && any_ready;

  // Search ptr+1, ptr+2, ptr+3, then ptr itself; the 2-bit add wraps modulo 4.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && !src_empty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign src_rd = grant ? (N_SRC'(1) << winner) : '0;

  // Source data is valid the cycle after the pop, exactly when the push strobe is high.
  assign dest_fifo_in = dest_fifo_wr ? src_data[DATA_W*int'(rd_idx) +: DATA_W] : '0;
  assign idle         = (st == ST_IDLE) && !dest_fifo_wr;
  assign state        = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= ST_RESET;
      ptr          <= 2'd3;
      rd_idx       <= 2'd0;
      dest_fifo_wr <= 1'b0;
      full_umbral  <= '0;
      empty_umbral <= '0;
    end else begin
      dest_fifo_wr <= grant;
      if (grant) begin
        rd_idx <= winner;
        ptr    <= winner;
      end
      if (init) begin
        full_umbral  <= full_umbral_in;
        empty_umbral <= empty_umbral_in;
      end
      if (init) begin
        st <= ST_INIT;
      end else begin
        case (st)
          ST_RESET:  st <= ST_INIT;
          ST_INIT:   st <= ST_IDLE;
          ST_IDLE:   if (any_ready && !dest_almost_full) st <= ST_ACTIVE;
          ST_ACTIVE: if (!any_ready || dest_almost_full) st <= ST_IDLE;
          default:   st <= ST_RESET;
        endcase
      end
    end
  end

endmodule
